updown_mod_counter: RTL and testbench

Parametrised synchronous up/down modulo counter. It is the next generation of the 3-bit ripple counter in our counter library: a single-clock, fully synchronous design that replaces rippled stage clocks. It adds programmable width and modulus, direction control, count enable, parallel load, terminal-count detection and a registered wrap pulse. It serves as the general-purpose counter/divider for the lab datapath and sequencing blocks.

---
 rtl/updown_mod_counter.sv | 71 +++++++
 tb/tb_updown_mod_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulo counter with load, terminal count and wrap pulse.
// Define UPDOWN_MOD_COUNTER_SATURATE_EN to saturate at 0/MAX instead of wrapping.
module updown_mod_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (Q == MAX);
    assign at_zero = (Q == '0);
    assign Tc      = En & ((Up & at_max) | (~Up & at_zero));

    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        if (Load) begin
            q_next = (D > MAX) ? MAX : D;
        end else if (En) begin
            if (Up) begin
                if (at_max) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
                    q_next    = MAX;
`else
                    q_next    = '0;
                    wrap_next = 1'b1;
`endif
                end else begin
                    q_next = Q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
                    q_next    = '0;
`else
                    q_next    = MAX;
                    wrap_next = 1'b1;
`endif
                end else begin
                    q_next = Q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Q    <= '0;
            Wrap <= 1'b0;
        end else begin
            Q    <= q_next;
            Wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: vector table, hand sequences, random run vs model.
// Covers MODULUS=8 and MODULUS=6 instances driven by the same inputs.
module tb_updown_mod_counter;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       En = 1'b0;
    logic       Up = 1'b0;
    logic       Load = 1'b0;
    logic [2:0] D = 3'd0;
    logic [2:0] q8, q6;
    logic       t8, t6, w8, w6;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    updown_mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
        .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Load(Load), .D(D),
        .Q(q8), .Tc(t8), .Wrap(w8)
    );

    updown_mod_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
        .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Load(Load), .D(D),
        .Q(q6), .Tc(t6), .Wrap(w6)
    );

    typedef struct {
        logic       load, en, up;
        logic [2:0] d;
        int         q8;
        logic       w8, t8;
        int         q6;
        logic       w6, t6;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic add(input logic l, input logic e, input logic u,
                       input int d, input int a8, input logic b8,
                       input logic c8, input int a6, input logic b6,
                       input logic c6);
        vec_t v;
        v.load = l; v.en = e; v.up = u; v.d = 3'(d);
        v.q8 = a8; v.w8 = b8; v.t8 = c8;
        v.q6 = a6; v.w6 = b6; v.t6 = c6;
        tbl.push_back(v);
    endtask

    // Reference: next count from the rules, using plain modulo arithmetic.
    function automatic void step(input int m, input int q, input logic l,
                                 input logic e, input logic u, input int d,
                                 output int qn, output int wn);
        int mx;
        mx = m - 1;
        wn = 0;
        qn = q;
        if (l) begin
            qn = (d > mx) ? mx : d;
        end else if (e) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
            if (u) qn = (q >= mx) ? mx : q + 1;
            else   qn = (q <= 0) ? 0 : q - 1;
`else
            if (u) begin
                qn = (q + 1) % m;
                wn = (q == mx) ? 1 : 0;
            end else begin
                qn = (q + m - 1) % m;
                wn = (q == 0) ? 1 : 0;
            end
`endif
        end
    endfunction

    function automatic int tc_of(input int m, input int q, input logic e,
                                 input logic u);
        if (!e) return 0;
        return u ? int'(q == m - 1) : int'(q == 0);
    endfunction

    task automatic drive(input logic l, input logic e, input logic u,
                         input int d);
        Load = l; En = e; Up = u; D = 3'(d);
    endtask

    initial begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
        for (int i = 0; i < 10; i++)
            add(0, 1, 1, 0, (i < 7) ? i + 1 : 7, 0, i >= 6,
                (i < 5) ? i + 1 : 5, 0, i >= 4);
        for (int i = 0; i < 10; i++)
            add(0, 1, 0, 0, (i < 7) ? 6 - i : 0, 0, i >= 6,
                (i < 5) ? 4 - i : 0, 0, i >= 4);
        add(1, 1, 1, 3, 3, 0, 0, 3, 0, 0);
        add(1, 0, 1, 7, 7, 0, 0, 5, 0, 0);
`else
        add(0, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 1, 0, 2, 0, 0, 2, 0, 0);
        add(0, 1, 1, 0, 3, 0, 0, 3, 0, 0);
        add(0, 1, 1, 0, 4, 0, 0, 4, 0, 0);
        add(0, 1, 1, 0, 5, 0, 0, 5, 0, 1);
        add(0, 1, 1, 0, 6, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 7, 0, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 2, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 3, 0, 0);
        add(0, 1, 1, 0, 2, 0, 0, 4, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 7, 1, 0, 5, 1, 0);
        add(0, 1, 0, 0, 6, 0, 0, 4, 0, 0);
        add(0, 1, 0, 0, 5, 0, 0, 3, 0, 0);
        add(0, 1, 0, 0, 4, 0, 0, 2, 0, 0);
        add(0, 1, 0, 0, 3, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 2, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 0, 5, 1, 0);
        add(1, 1, 1, 3, 3, 0, 0, 3, 0, 0);
        add(1, 0, 1, 7, 7, 0, 0, 5, 0, 0);
        add(1, 0, 1, 4, 4, 0, 0, 4, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, 0, 4, 0, 0, 4, 0, 0);
        add(1, 0, 1, 7, 7, 0, 0, 5, 0, 0);
        add(0, 0, 1, 0, 7, 0, 0, 5, 0, 0);
        add(0, 1, 0, 0, 6, 0, 0, 4, 0, 0);
`endif

        // reset state, including Tc response while held in reset
        #1;
        chk("rst_q8", 32'(q8), 0);
        chk("rst_w8", 32'(w8), 0);
        chk("rst_t8", 32'(t8), 0);
        chk("rst_q6", 32'(q6), 0);
        drive(0, 1, 0, 0);
        #1;
        chk("rst_tc_down8", 32'(t8), 1);
        chk("rst_tc_down6", 32'(t6), 1);
        @(negedge Clk);
        drive(0, 0, 1, 0);
        @(negedge Clk);
        Rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge Clk);
            drive(tbl[i].load, tbl[i].en, tbl[i].up, int'(tbl[i].d));
            @(posedge Clk);
            #1;
            chk($sformatf("tbl%0d_q8", i), 32'(q8), 32'(tbl[i].q8));
            chk($sformatf("tbl%0d_w8", i), 32'(w8), 32'(tbl[i].w8));
            chk($sformatf("tbl%0d_t8", i), 32'(t8), 32'(tbl[i].t8));
            chk($sformatf("tbl%0d_q6", i), 32'(q6), 32'(tbl[i].q6));
            chk($sformatf("tbl%0d_w6", i), 32'(w6), 32'(tbl[i].w6));
            chk($sformatf("tbl%0d_t6", i), 32'(t6), 32'(tbl[i].t6));
        end

        // asynchronous reset mid-count, pending load discarded
        @(negedge Clk);
        drive(1, 0, 1, 5);
        @(posedge Clk);
        #1;
        chk("pre_rst_q8", 32'(q8), 5);
        #2;
        drive(1, 1, 1, 6);
        Rst = 1'b1;
        #1;
        chk("async_q8", 32'(q8), 0);
        chk("async_q6", 32'(q6), 0);
        chk("async_w8", 32'(w8), 0);
        @(posedge Clk);
        #1;
        chk("rst_hold_q8", 32'(q8), 0);
        @(negedge Clk);
        Rst = 1'b0;
        drive(0, 1, 1, 0);
        @(posedge Clk);
        #1;
        chk("rel_q8", 32'(q8), 1);
        chk("rel_q6", 32'(q6), 1);

        // randomized run against the reference model
        begin
            int m8q, m6q, n8, n6, wa, wb, dv;
            logic l, e, u, r;
            m8q = 1;
            m6q = 1;
            for (int i = 0; i < 600; i++) begin
                @(negedge Clk);
                r = ($urandom_range(0, 40) == 0);
                l = ($urandom_range(0, 7) == 0);
                e = ($urandom_range(0, 3) != 0);
                u = ($urandom_range(0, 3) != 0) ^ (i[6]);
                dv = int'($urandom_range(0, 7));
                drive(l, e, u, dv);
                Rst = r;
                #1;
                if (r) begin
                    m8q = 0;
                    m6q = 0;
                    chk("rnd_rst_q8", 32'(q8), 0);
                    chk("rnd_rst_q6", 32'(q6), 0);
                end
                chk("rnd_tc8", 32'(t8), 32'(tc_of(8, m8q, e, u)));
                chk("rnd_tc6", 32'(t6), 32'(tc_of(6, m6q, e, u)));
                @(posedge Clk);
                #1;
                if (r) begin
                    n8 = 0; n6 = 0; wa = 0; wb = 0;
                end else begin
                    step(8, m8q, l, e, u, dv, n8, wa);
                    step(6, m6q, l, e, u, dv, n6, wb);
                end
                m8q = n8;
                m6q = n6;
                chk("rnd_q8", 32'(q8), 32'(n8));
                chk("rnd_w8", 32'(w8), 32'(wa));
                chk("rnd_q6", 32'(q6), 32'(n6));
                chk("rnd_w6", 32'(w6), 32'(wb));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
